// File: rtl/alu_op_qdec.sv
// -----------------------------------------------------------------------------
// alu_op_qdec
//   Decodes a 3-bit select code {A,B,C} into a 4-bit ALU op and queues the
//   result in a DEPTH-entry circular buffer with valid/ready on both sides.
//   The op is zero-extended to OP_W bits before it is stored.
//
// Parameters
//   DEPTH : queue entries (power of two, >= 2)
//   OP_W  : width of out_op (>= 4)
//
// Ports
//   clk       in   single clock, rising edge
//   rst       in   asynchronous, active-high reset
//   in_valid  in   in_sel is valid this cycle
//   in_ready  out  queue can accept a code (registered state only)
//   in_sel    in   select code {A,B,C}
//   flush     in   drop every queued entry at the next edge
//   out_valid out  out_op holds a decoded entry
//   out_ready in   consumer takes the head entry this cycle
//   out_op    out  decoded op at the head of the queue, zero when empty
//   level     out  number of queued entries
//   perf_cnt  out  saturating count of accepted pushes
//                  (present only when ALU_OP_QDEC_PERF_EN is defined)
// -----------------------------------------------------------------------------
module alu_op_qdec #(
  parameter int DEPTH = 4,
  parameter int OP_W  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2:0]             in_sel,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OP_W-1:0]        out_op,
  output logic [$clog2(DEPTH):0] level
`ifdef ALU_OP_QDEC_PERF_EN
  ,
  output logic [15:0]            perf_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  function automatic logic [3:0] decode_sel(input logic [2:0] sel);
    logic [3:0] op;
    case (sel)
      3'b000:  op = 4'b0010;
      3'b001:  op = 4'b0000;
      3'b010:  op = 4'b1101;
      3'b011:  op = 4'b1001;
      3'b100:  op = 4'b0100;
      3'b101:  op = 4'b0001;
      3'b110:  op = 4'b0111;
      default: op = 4'b1010;
    endcase
    return op;
  endfunction

  logic [OP_W-1:0] mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            push;
  logic            pop;

  // Handshake flags come from level alone, so in_ready never sees out_ready
  // and a full queue refuses a push even when a pop happens the same cycle.
  assign in_ready  = (level != LW'(DEPTH));
  assign out_valid = (level != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  // Head is gated so the output reads zero while empty (stale storage hidden).
  assign out_op = out_valid ? mem[rd_ptr] : '0;

  // Control state: pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;
    end
  end

  // Storage: data only, never reset; the cast zero-extends the 4-bit op.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= OP_W'(decode_sel(in_sel));
  end

`ifdef ALU_OP_QDEC_PERF_EN
  // Accepted-push counter; survives flush, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           perf_cnt <= '0;
    else if (push && perf_cnt != 16'hFFFF) perf_cnt <= perf_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_alu_op_qdec.sv
// -----------------------------------------------------------------------------
// tb_alu_op_qdec
//   Self-checking bench for alu_op_qdec. A queue-based reference model holds
//   the expected contents; directed phases (decode sweep, fill, full push+pop,
//   wrap-around, flush, async reset) are followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_alu_op_qdec;

  localparam int DEPTH = 4;
  localparam int OP_W  = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      in_sel;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [OP_W-1:0] out_op;
  logic [LW-1:0]   level;
`ifdef ALU_OP_QDEC_PERF_EN
  logic [15:0]     perf_cnt;
`endif

  alu_op_qdec #(.DEPTH(DEPTH), .OP_W(OP_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_op    (out_op),
    .level     (level)
`ifdef ALU_OP_QDEC_PERF_EN
    ,
    .perf_cnt  (perf_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  int dec_tab [8] = '{2, 0, 13, 9, 4, 1, 7, 10};
  int model_q [$];
  int perf_exp = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, check the
  // registered-state outputs against the model, then advance the model.
  task automatic cycle(input logic v, input logic [2:0] s,
                       input logic r, input logic f);
    bit do_push;
    bit do_pop;
    @(negedge clk);
    in_valid  = v;
    in_sel    = s;
    out_ready = r;
    flush     = f;
    #1;
    check_eq("level",     int'(level),     model_q.size());
    check_eq("out_valid", int'(out_valid), int'(model_q.size() != 0));
    check_eq("in_ready",  int'(in_ready),  int'(model_q.size() != DEPTH));
    check_eq("out_op",    int'(out_op),    (model_q.size() != 0) ? model_q[0] : 0);
`ifdef ALU_OP_QDEC_PERF_EN
    check_eq("perf_cnt",  int'(perf_cnt),  perf_exp);
`endif
    do_push = v && (model_q.size() < DEPTH) && !f;
    do_pop  = r && (model_q.size() > 0) && !f;
    @(posedge clk);
    if (f) begin
      model_q.delete();
    end else begin
      if (do_pop)  void'(model_q.pop_front());
      if (do_push) begin
        model_q.push_back(dec_tab[s]);
        if (perf_exp < 65535) perf_exp++;
      end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sel = 3'd0; out_ready = 1'b0; flush = 1'b0;
    #1;
    check_eq("rst_level",    int'(level),     0);
    check_eq("rst_out_valid",int'(out_valid), 0);
    check_eq("rst_out_op",   int'(out_op),    0);
    check_eq("rst_in_ready", int'(in_ready),  1);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Decode sweep with the consumer always ready; the first push lands on
    // the first edge after reset release.
    for (int i = 0; i < 8; i++) cycle(1'b1, 3'(i), 1'b1, 1'b0);
    cycle(1'b0, 3'd0, 1'b1, 1'b0);
    cycle(1'b0, 3'd0, 1'b1, 1'b0);

    // Fill: five offered codes with the consumer stalled, then hold.
    for (int i = 0; i < 5; i++) cycle(1'b1, 3'(i + 2), 1'b0, 1'b0);
    cycle(1'b1, 3'd6, 1'b0, 1'b0);
    // Full push+pop: only the pop happens, the push is taken next cycle.
    cycle(1'b1, 3'd6, 1'b1, 1'b0);
    cycle(1'b1, 3'd6, 1'b0, 1'b0);
    cycle(1'b0, 3'd0, 1'b0, 1'b0);

    // Drain, then wrap-around with interleaved pops.
    for (int i = 0; i < 5; i++) cycle(1'b0, 3'd0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b1, 3'(7 - (i % 8)), 1'(i % 2), 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b0, 3'd0, 1'b1, 1'b0);

    // Flush while pushing at level 3.
    for (int i = 0; i < 3; i++) cycle(1'b1, 3'(i), 1'b0, 1'b0);
    cycle(1'b1, 3'd4, 1'b1, 1'b1);
    cycle(1'b0, 3'd0, 1'b0, 1'b0);

    // Async reset between edges at level 2.
    cycle(1'b1, 3'd3, 1'b0, 1'b0);
    cycle(1'b1, 3'd5, 1'b0, 1'b0);
    cycle(1'b0, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst_level",     int'(level),     0);
    check_eq("arst_out_valid", int'(out_valid), 0);
    check_eq("arst_out_op",    int'(out_op),    0);
    check_eq("arst_in_ready",  int'(in_ready),  1);
`ifdef ALU_OP_QDEC_PERF_EN
    check_eq("arst_perf_cnt",  int'(perf_cnt),  0);
`endif
    model_q.delete();
    perf_exp = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    cycle(1'b1, 3'd5, 1'b0, 1'b0);
    cycle(1'b0, 3'd0, 1'b1, 1'b0);

    // Randomized traffic with occasional flushes.
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 31) == 0));
    for (int i = 0; i < 6; i++) cycle(1'b0, 3'd0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
